// File: rtl/genius_pkg.sv
// genius_pkg: shared types and constants for the Genius sequence generator.
//   - SYMBOL_W_DEF : default bits per symbol
//   - symbol_t     : symbol as stored in the preset tables
//   - mode_e       : fill source (preset 0..3, or random for codes 4..7)
//   - state_e      : fill controller states
//   - PRESETn_TAB  : 16-entry preset patterns, entry 0 in the top two bits
//   - LFSR_SEED / LFSR_TAPS : default seed and Galois tap mask
//     (x^16 + x^14 + x^13 + x^11 + 1, right-shifting form)
package genius_pkg;

  localparam int SYMBOL_W_DEF = 2;
  localparam int PRESET_LEN   = 16;

  typedef logic [SYMBOL_W_DEF-1:0] symbol_t;

  typedef enum logic [2:0] {
    PRESET0 = 3'd0,
    PRESET1 = 3'd1,
    PRESET2 = 3'd2,
    PRESET3 = 3'd3,
    RANDOM  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Tables are written in playback order: the leftmost value is entry 0.
  localparam logic [31:0] PRESET0_TAB = {2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2,
                                         2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
  localparam logic [31:0] PRESET1_TAB = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1,
                                         2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  localparam logic [31:0] PRESET2_TAB = {2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd1, 2'd2,
                                         2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
  localparam logic [31:0] PRESET3_TAB = {2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2,
                                         2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2};

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Raw preset entry; callers reduce it into their own symbol range.
  function automatic symbol_t preset_lookup(input logic [1:0] sel, input logic [3:0] idx);
    logic [31:0] tab;
    logic [3:0]  ridx;
    case (sel)
      2'd0:    tab = PRESET0_TAB;
      2'd1:    tab = PRESET1_TAB;
      2'd2:    tab = PRESET2_TAB;
      default: tab = PRESET3_TAB;
    endcase
    ridx = 4'd15 - idx;
    return tab[{ridx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// genius_lfsr: parametrised right-shifting Galois LFSR.
//   clock, reset  : clock, asynchronous active-high reset (state <= INIT)
//   load/load_val : synchronous load, takes priority over enable
//   enable        : advance one step
//   sym_bits      : low OUT_W bits of the current state
module genius_lfsr
  import genius_pkg::*;
#(
  parameter int           W     = 16,
  parameter int           OUT_W = 2,
  parameter logic [W-1:0] TAPS  = W'(LFSR_TAPS),
  parameter logic [W-1:0] INIT  = W'(LFSR_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             enable,
  output logic [OUT_W-1:0] sym_bits
);

  logic [W-1:0] state;

  function automatic logic [W-1:0] galois_step(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else if (load) begin
      state <= load_val;
    end else if (enable) begin
      state <= galois_step(state);
    end
  end

  assign sym_bits = state[OUT_W-1:0];

endmodule

// File: rtl/genius_sequence_gen.sv
// genius_sequence_gen: fills a DEPTH-entry symbol buffer from a preset
// pattern or a seeded LFSR on a start edge, then serves it through a
// registered indexed read port.
//   clock, reset             : clock, asynchronous active-high reset
//   start                    : level; a rising edge requests a new fill
//   mode                     : 0..3 preset pattern, 4..7 random (sampled on accept)
//   seed                     : LFSR seed for random mode, 0 selects the default
//   sequence_count           : read index
//   current_sequence_number  : symbol at sequence_count, one cycle later
//   rd_valid                 : read data comes from a completed fill
//   busy / ready             : fill in progress / buffer complete
module genius_sequence_gen
  import genius_pkg::*;
#(
  parameter int NUM_SYMBOLS = 3,
  parameter int SYMBOL_W    = SYMBOL_W_DEF,
  parameter int DEPTH       = 16,
  parameter int IDX_W       = 4,
  parameter int LFSR_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [LFSR_W-1:0]   seed,
  input  logic [IDX_W-1:0]    sequence_count,
  output logic [SYMBOL_W-1:0] current_sequence_number,
  output logic                rd_valid,
  output logic                busy,
  output logic                ready
);

  function automatic logic [SYMBOL_W-1:0] wrap_symbol(input symbol_t raw);
    return SYMBOL_W'(int'(raw) % NUM_SYMBOLS);
  endfunction

  function automatic logic sym_in_range(input logic [SYMBOL_W-1:0] c);
    return int'(c) < NUM_SYMBOLS;
  endfunction

  state_e              state;
  logic [2:0]          mode_r;
  logic [IDX_W-1:0]    wp;
  logic                start_q;
  logic                start_q_vld;
  logic                start_edge;
  logic                accept;
  logic                is_random;
  logic [SYMBOL_W-1:0] cand;
  logic [SYMBOL_W-1:0] wr_data;
  logic                wr_en;
  logic                last_wr;
  logic [LFSR_W-1:0]   lfsr_load_val;
  logic [SYMBOL_W-1:0] seq_mem [DEPTH];

  // start_q only counts as history once it has sampled start after reset;
  // otherwise a start held high through reset would look like a fresh edge.
  assign start_edge = start & ~start_q & start_q_vld;
  assign accept     = start_edge & (state != ST_FILL);

  assign is_random     = (mode_r >= RANDOM);
  assign lfsr_load_val = (seed == '0) ? LFSR_W'(LFSR_SEED) : seed;

  genius_lfsr #(
    .W     (LFSR_W),
    .OUT_W (SYMBOL_W),
    .TAPS  (LFSR_W'(LFSR_TAPS)),
    .INIT  (LFSR_W'(LFSR_SEED))
  ) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (lfsr_load_val),
    .enable   ((state == ST_FILL) & is_random),
    .sym_bits (cand)
  );

  // Presets repeat every 16 entries for deeper buffers.
  assign wr_data = is_random ? cand : wrap_symbol(preset_lookup(mode_r[1:0], 4'(wp)));
  assign wr_en   = (state == ST_FILL) & (~is_random | sym_in_range(cand));
  assign last_wr = wr_en & (wp == IDX_W'(DEPTH - 1));

  // Fill controller
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      start_q_vld <= 1'b0;
      mode_r      <= '0;
      wp          <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
    end else begin
      start_q     <= start;
      start_q_vld <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            mode_r <= mode;
            wp     <= '0;
            busy   <= 1'b1;
            ready  <= 1'b0;
            state  <= ST_FILL;
          end
        end
        ST_FILL: begin
          // wp parks on the last entry instead of wrapping over old data.
          if (last_wr) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= ST_DONE;
          end else if (wr_en) begin
            wp <= wp + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      seq_mem[wp] <= wr_data;
    end
  end

  // Read stage: one-cycle registered lookup, gated by ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      current_sequence_number <= '0;
      rd_valid                <= 1'b0;
    end else begin
      current_sequence_number <= ready ? seq_mem[sequence_count] : '0;
      rd_valid                <= ready;
    end
  end

endmodule

// File: tb/tb_genius_sequence_gen.sv
// Bench for genius_sequence_gen: default build (3 symbols, depth 16) plus a
// 4-symbol, depth-32 build. Expected data comes from the preset tables and an
// arithmetic LFSR model kept here.
module tb_genius_sequence_gen;

  localparam int NSYM = 3;
  localparam int SW   = 2;
  localparam int DEP  = 16;
  localparam int IW   = 4;
  localparam int LW   = 16;
  localparam int DEP4 = 32;
  localparam int IW4  = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode  = '0;
  logic [LW-1:0] seed  = '0;
  logic [IW-1:0] sequence_count = '0;
  logic [SW-1:0] current_sequence_number;
  logic          rd_valid, busy, ready;

  logic           start4 = 1'b0;
  logic [2:0]     mode4  = '0;
  logic [LW-1:0]  seed4  = '0;
  logic [IW4-1:0] count4 = '0;
  logic [SW-1:0]  cur4;
  logic           rd_valid4, busy4, ready4;

  always #5 clock = ~clock;

  genius_sequence_gen #(
    .NUM_SYMBOLS(NSYM), .SYMBOL_W(SW), .DEPTH(DEP), .IDX_W(IW), .LFSR_W(LW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .sequence_count(sequence_count), .current_sequence_number(current_sequence_number),
    .rd_valid(rd_valid), .busy(busy), .ready(ready)
  );

  genius_sequence_gen #(
    .NUM_SYMBOLS(4), .SYMBOL_W(SW), .DEPTH(DEP4), .IDX_W(IW4), .LFSR_W(LW)
  ) dut4 (
    .clock(clock), .reset(reset), .start(start4), .mode(mode4), .seed(seed4),
    .sequence_count(count4), .current_sequence_number(cur4),
    .rd_valid(rd_valid4), .busy(busy4), .ready(ready4)
  );

  int checks = 0;
  int errors = 0;
  int ptab [4][16];
  int exp_s [64];
  int got1 [16];
  int exp_cyc;
  int n;

  typedef struct {
    int mode;
    int idx;
    int exp;
  } vec_t;
  vec_t vecs [12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    // x^16+x^14+x^13+x^11+1 in Galois form: shift right, fold taps on a 1 out
    return (s >> 1) ^ ((s[0] == 1'b1) ? 16'hB400 : 16'h0000);
  endfunction

  // Expected buffer contents and fill length for one fill.
  function automatic void model_fill(input int m, input logic [15:0] sd, input int nsym,
                                     input int depth, output int syms [64], output int cycles);
    logic [15:0] s;
    int cnt;
    int c;
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    cnt = 0;
    cycles = 0;
    for (int i = 0; i < 64; i++) syms[i] = 0;
    if (m < 4) begin
      for (int i = 0; i < depth; i++) syms[i] = ptab[m][i % 16] % nsym;
      cycles = depth;
    end else begin
      while (cnt < depth && cycles < 10000) begin
        cycles++;
        c = int'(s & 16'h0003);
        if (c < nsym) begin
          syms[cnt] = c;
          cnt++;
        end
        s = lfsr_next(s);
      end
    end
  endfunction

  task automatic run_fill(input int m, input logic [15:0] sd, output int ncyc);
    mode  = 3'(m);
    seed  = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
    ncyc  = 0;
    while (busy === 1'b1 && ncyc < 1000) begin
      ncyc++;
      tick();
    end
  endtask

  task automatic read_idx(input int idx, input int exp, input string name);
    sequence_count = IW'(idx);
    tick();
    check(name, 32'(current_sequence_number), exp);
    check({name, "_vld"}, 32'(rd_valid), 1);
  endtask

  initial begin
    int cur_mode;
    int m;
    logic [15:0] sd;

    ptab = '{'{2,1,0,1,0,2,0,2,0,1,0,2,0,1,0,1},
             '{2,1,0,2,1,0,2,1,1,0,2,0,1,2,0,1},
             '{0,2,1,0,2,1,1,2,0,1,0,2,1,0,2,1},
             '{2,1,0,2,0,1,1,2,0,2,1,0,0,2,1,2}};
    vecs = '{'{0, 0, 2}, '{0, 5, 2}, '{0, 15, 1},
             '{1, 3, 2}, '{1, 8, 1}, '{1, 13, 2},
             '{2, 0, 0}, '{2, 7, 2}, '{2, 15, 1},
             '{3, 0, 2}, '{3, 9, 2}, '{3, 15, 2}};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_cur", 32'(current_sequence_number), 0);
    check("rst_vld", 32'(rd_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    reset = 1'b0;
    tick();
    tick();
    sequence_count = 4'd3;
    tick();
    check("idle_cur", 32'(current_sequence_number), 0);
    check("idle_vld", 32'(rd_valid), 0);

    // Preset spot checks from the table
    cur_mode = -1;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].mode != cur_mode) begin
        run_fill(vecs[i].mode, 16'h0, n);
        check($sformatf("fill_len_m%0d", vecs[i].mode), n, 16);
        check($sformatf("fill_ready_m%0d", vecs[i].mode), 32'(ready), 1);
        cur_mode = vecs[i].mode;
      end
      read_idx(vecs[i].idx, vecs[i].exp, $sformatf("vec%0d_m%0d_i%0d", i, vecs[i].mode, vecs[i].idx));
    end

    // Full sweep of preset 3 (buffer still holds it)
    model_fill(3, 16'h0, NSYM, DEP, exp_s, exp_cyc);
    for (int i = 0; i < DEP; i++) read_idx(i, exp_s[i], $sformatf("p3_sweep_%0d", i));

    // Random mode, seed 1234, twice, must be identical and in range
    model_fill(4, 16'h1234, NSYM, DEP, exp_s, exp_cyc);
    run_fill(4, 16'h1234, n);
    check("rnd1_len", n, exp_cyc);
    for (int i = 0; i < DEP; i++) begin
      read_idx(i, exp_s[i], $sformatf("rnd1_%0d", i));
      got1[i] = int'(current_sequence_number);
      check($sformatf("rnd1_range_%0d", i), 32'(got1[i] <= 2), 1);
    end
    run_fill(5, 16'h1234, n);
    check("rnd2_len", n, exp_cyc);
    for (int i = 0; i < DEP; i++) read_idx(i, got1[i], $sformatf("rnd2_same_%0d", i));

    // Seed 0 behaves as the default seed
    model_fill(4, 16'hACE1, NSYM, DEP, exp_s, exp_cyc);
    run_fill(6, 16'h0000, n);
    check("seed0_len", n, exp_cyc);
    for (int i = 0; i < DEP; i++) read_idx(i, exp_s[i], $sformatf("seed0_%0d", i));

    // Randomized fills against the model
    for (int k = 0; k < 5; k++) begin
      m  = int'($urandom_range(0, 7));
      sd = 16'($urandom);
      model_fill(m, sd, NSYM, DEP, exp_s, exp_cyc);
      run_fill(m, sd, n);
      check($sformatf("urnd%0d_len_m%0d", k, m), n, exp_cyc);
      for (int j = 0; j < 4; j++) begin
        int idx;
        idx = int'($urandom_range(0, DEP - 1));
        read_idx(idx, exp_s[idx], $sformatf("urnd%0d_m%0d_i%0d", k, m, idx));
      end
    end

    // Restart from DONE: ready drops next cycle, reads blank during fill
    sequence_count = 4'd0;
    mode  = 3'd0;
    start = 1'b1;
    tick();
    check("restart_ready", 32'(ready), 0);
    check("restart_busy", 32'(busy), 1);
    start = 1'b0;
    tick();
    check("fill_read_cur", 32'(current_sequence_number), 0);
    check("fill_read_vld", 32'(rd_valid), 0);
    n = 1;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    check("restart_len", n, 16);

    // Start edge in the middle of a fill is ignored
    mode  = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      start = (n == 5);
      tick();
    end
    start = 1'b0;
    check("midfill_len", n, 16);
    tick();
    tick();
    tick();
    check("midfill_noqueue_busy", 32'(busy), 0);
    check("midfill_noqueue_ready", 32'(ready), 1);
    read_idx(3, 2, "midfill_m1_i3");

    // Start edge coinciding with the last write is ignored
    mode  = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      start = (n == 16);
      tick();
    end
    start = 1'b0;
    check("lastwr_len", n, 16);
    check("lastwr_ready", 32'(ready), 1);
    tick();
    tick();
    check("lastwr_busy_after", 32'(busy), 0);
    check("lastwr_ready_after", 32'(ready), 1);
    read_idx(7, 2, "lastwr_m2_i7");

    // Start held high across reset does not fill
    start = 1'b1;
    reset = 1'b1;
    tick();
    check("hold_rst_ready", 32'(ready), 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy === 1'b1) n++;
    end
    check("hold_no_fill", n, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("hold_toggle_busy", 32'(busy), 1);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    check("hold_toggle_ready", 32'(ready), 1);

    // Reset at fill cycle 7 aborts
    mode  = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(ready), 0);
    check("abort_cur", 32'(current_sequence_number), 0);
    check("abort_vld", 32'(rd_valid), 0);
    tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready === 1'b1 || busy === 1'b1) n++;
    end
    check("abort_stays_idle", n, 0);
    model_fill(3, 16'h0, NSYM, DEP, exp_s, exp_cyc);
    run_fill(3, 16'h0, n);
    check("abort_refill_len", n, 16);
    read_idx(4, exp_s[4], "abort_refill_i4");

    // Four-symbol, depth-32 build: random never rejects
    sd = 16'($urandom_range(1, 65535));
    model_fill(4, sd, 4, DEP4, exp_s, exp_cyc);
    mode4  = 3'd4;
    seed4  = sd;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (busy4 === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
    check("d32_len", n, 32);
    check("d32_ready", 32'(ready4), 1);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (i == 0) ? 31 : int'($urandom_range(0, DEP4 - 1));
      count4 = IW4'(idx);
      tick();
      check($sformatf("d32_i%0d", idx), 32'(cur4), exp_s[idx]);
      check($sformatf("d32_i%0d_vld", idx), 32'(rd_valid4), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
